// File: rtl/memory_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and memory (slave).
interface memory_access_stage_if;
    logic        dmem_req;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_strobe;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_wen,
        output dmem_addr,
        output dmem_wdata,
        output dmem_strobe,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_wen,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_strobe,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage: data-memory access, load alignment, MEM/WB latch.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module memory_access_stage #(
    parameter int CTRL_W      = 96,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [1:0]            ex_mem_size,
    input  logic                  ex_mem_signed,
    input  logic [31:0]           ex_alu_out,
    input  logic [31:0]           ex_store_data,
    input  logic [CTRL_W-1:0]     ex_ctrl,
    output logic                  mem_stall,
    memory_access_stage_if.master bus,
    output logic                  mw_valid,
    output logic [CTRL_W-1:0]     mw_ctrl,
    output logic [31:0]           mw_alu_out,
    output logic [31:0]           mw_dload,
    output logic                  mw_fault
);
    typedef enum logic {IDLE, REQ} state_t;

    localparam logic [31:0] TO_LAST = 32'(ACK_TIMEOUT) - 32'd1;

    state_t state_q, state_d;

    logic              wen_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        strobe_q;
    logic [1:0]        size_q;
    logic [1:0]        lane_q;
    logic              signed_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [31:0]       alu_q;
    logic              flush_q;
    logic [31:0]       cnt_q;

    logic              mw_valid_q;
    logic              mw_fault_q;
    logic [CTRL_W-1:0] mw_ctrl_q;
    logic [31:0]       mw_alu_q;
    logic [31:0]       mw_dload_q;

    logic        op, sz_byte, sz_half, misal, trap, issue;
    logic        ack, timeout, req, kill;
    logic [1:0]  lane;
    logic [3:0]  lane_mask, strobe_d;
    logic [31:0] wdata_d, rsh, dload_d;

    assign op      = ex_valid & (ex_mem_read | ex_mem_write);
    assign lane    = ex_alu_out[1:0];
    assign sz_byte = (ex_mem_size == 2'd0);
    assign sz_half = (ex_mem_size == 2'd1);
    assign misal   = (sz_half & (lane == 2'd3))
                   | (!sz_byte & !sz_half & (lane != 2'd0));

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = op & misal;
`else
    assign trap = 1'b0;
`endif

    assign issue   = op & !flush & !trap;
    assign ack     = (state_q == REQ) & bus.dmem_ack;
    assign timeout = (ACK_TIMEOUT != 0) && (state_q == REQ)
                  && !bus.dmem_ack && (cnt_q == TO_LAST);
    assign kill    = flush_q | flush;

    // Stores replicate into every lane; misaligned accesses drop lanes past byte 3.
    always_comb begin
        lane_mask = 4'b1111;
        wdata_d   = ex_store_data;
        unique case (1'b1)
            sz_byte: begin
                lane_mask = 4'b0001;
                wdata_d   = {4{ex_store_data[7:0]}};
            end
            sz_half: begin
                lane_mask = 4'b0011;
                wdata_d   = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
        strobe_d = 4'b1111;
        if (ex_mem_write | misal) strobe_d = lane_mask << lane;
    end

    always_comb begin
        rsh     = bus.dmem_rdata >> {lane_q, 3'b000};
        dload_d = bus.dmem_rdata;
        unique case (size_q)
            2'd0:    dload_d = {{24{signed_q & rsh[7]}}, rsh[7:0]};
            2'd1:    dload_d = {{16{signed_q & rsh[15]}}, rsh[15:0]};
            default: ;
        endcase
        if (wen_q) dload_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (issue)          state_d = REQ;
            REQ:  if (ack | timeout)  state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall = 1'b0;
        req       = 1'b0;
        unique case (state_q)
            IDLE: mem_stall = issue;
            REQ: begin
                req       = 1'b1;
                mem_stall = !(ack | timeout);
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            strobe_q   <= '0;
            size_q     <= '0;
            lane_q     <= '0;
            signed_q   <= 1'b0;
            ctrl_q     <= '0;
            alu_q      <= '0;
            flush_q    <= 1'b0;
            cnt_q      <= '0;
            mw_valid_q <= 1'b0;
            mw_fault_q <= 1'b0;
            mw_ctrl_q  <= '0;
            mw_alu_q   <= '0;
            mw_dload_q <= '0;
        end else begin
            if (state_q == REQ && !bus.dmem_ack) cnt_q <= cnt_q + 32'd1;
            else if (state_q == IDLE)            cnt_q <= '0;
            unique case (state_q)
                IDLE: begin
                    flush_q <= 1'b0;
                    if (issue) begin
                        wen_q      <= ex_mem_write;
                        addr_q     <= {ex_alu_out[31:2], 2'b00};
                        wdata_q    <= wdata_d;
                        strobe_q   <= strobe_d;
                        size_q     <= ex_mem_size;
                        lane_q     <= lane;
                        signed_q   <= ex_mem_signed;
                        ctrl_q     <= ex_ctrl;
                        alu_q      <= ex_alu_out;
                        mw_valid_q <= 1'b0;
                        mw_fault_q <= 1'b0;
                    end else begin
                        mw_valid_q <= ex_valid & !flush;
                        mw_fault_q <= trap & !flush;
                        mw_ctrl_q  <= ex_ctrl;
                        mw_alu_q   <= ex_alu_out;
                        mw_dload_q <= '0;
                    end
                end
                REQ: begin
                    flush_q <= kill;
                    // A flushed access still completes on the bus; only the result is dropped.
                    if (ack | timeout) begin
                        mw_valid_q <= !kill;
                        mw_fault_q <= timeout & !kill;
                        mw_ctrl_q  <= ctrl_q;
                        mw_alu_q   <= alu_q;
                        mw_dload_q <= timeout ? 32'd0 : dload_d;
                    end
                end
            endcase
        end
    end

    assign bus.dmem_req    = req;
    assign bus.dmem_wen    = wen_q;
    assign bus.dmem_addr   = addr_q;
    assign bus.dmem_wdata  = wdata_q;
    assign bus.dmem_strobe = strobe_q;

    assign mw_valid   = mw_valid_q;
    assign mw_fault   = mw_fault_q;
    assign mw_ctrl    = mw_ctrl_q;
    assign mw_alu_out = mw_alu_q;
    assign mw_dload   = mw_dload_q;
endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
Pipeline MEM stage. Consumes the EX/MEM latch, issues data-memory load/store over a req/ack bus, aligns and extends load data, and registers the result into the MEM/WB latch (pc, halt, rd, register-write/CSR controls, alu_out, dload) read by writeback. Stalls upstream while an access is outstanding. Writeback never stalls this stage.

Parameters:
CTRL_W, 96, width of packed pass-through control bundle (pc, halt, rd, rs1, rdat1, reg_wr_src, reg_wr_mem, reg_wr_mem_signed, csr_*); carried opaque.
ACK_TIMEOUT, 255, max cycles waiting for dmem_ack before fault; 0 disables watchdog.

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
flush  in  1  squash instruction in this stage
ex_valid  in  1  EX/MEM latch holds a valid instruction
ex_mem_read  in  1  load
ex_mem_write  in  1  store
ex_mem_size  in  2  0 byte, 1 halfword, 2 word (3 treated as word)
ex_mem_signed  in  1  load sign-extend
ex_alu_out  in  32  effective address / ALU result
ex_store_data  in  32  store source (rs2), value in low bits
ex_ctrl  in  CTRL_W  pass-through bundle
mem_stall  out  1  hold EX/MEM and earlier stages
dmem_req  out  1  bus request
dmem_wen  out  1  1 store, 0 load
dmem_addr  out  32  word-aligned address (addr[1:0]=0)
dmem_wdata  out  32  lane-replicated store data
dmem_strobe  out  4  byte enables
dmem_ack  in  1  access complete; rdata valid same cycle
dmem_rdata  in  32  load word
mw_valid  out  1  MEM/WB latch valid
mw_ctrl  out  CTRL_W  latched bundle
mw_alu_out  out  32  latched ALU result
mw_dload  out  32  aligned, extended load data
mw_fault  out  1  access fault (timeout, or misaligned when enabled)

Behaviour:
- Reset (nRST=0 at edge): state IDLE; mw_valid, mw_fault, mw_ctrl, mw_alu_out, mw_dload, dmem_* outputs, timeout counter all 0.
- op = ex_valid & (ex_mem_read | ex_mem_write). Read and write both set: write wins.
- FSM IDLE / REQ.
- IDLE, no op: MEM/WB latch loads ex_* next edge (mw_valid=ex_valid&!flush, mw_dload=0, mw_fault=0); mem_stall=0.
- IDLE, op, no flush: mem_stall=1 combinationally. Capture addr/strobe/wdata/wen/size/signed/ctrl/alu_out into internal regs. Go to REQ. mw_valid=0 next edge (bubble).
- REQ: dmem_req=1, bus outputs driven from captured regs, stable until ack. mem_stall=!dmem_ack. On ack: mw_* load captured context, mw_dload from rdata, mw_valid=1, return to IDLE. Upstream advances on that same edge.
- Min mem-op latency 2 cycles (accept, ack-in-REQ). Non-mem throughput 1/cycle.
- Store: byte: wdata={4{sd[7:0]}}, strobe=1<<a[1:0]. Half: {2{sd[15:0]}}, strobe=0011<<a[1:0]. Word: sd, strobe=1111. Load strobe=1111.
- Load: byte=rdata>>(8*a[1:0]), half=rdata>>(8*a[1:0]), low 8/16 bits sign- or zero-extended per ex_mem_signed. Word: rdata unchanged.
- Misaligned without feature: half at a[1:0]=3 or word at a[1:0]≠0 masked to lanes in-word (strobe truncated at bit 3), no fault.
- Watchdog: counter clears on REQ entry and increments each REQ cycle without ack. At count==ACK_TIMEOUT-1 with no ack: drop dmem_req, return to IDLE, mw_valid=1, mw_fault=1, mw_dload=0, mem_stall=0. A later stray ack in IDLE is ignored.
- flush in IDLE: op not issued, mw_valid=0. flush in REQ: access not aborted (store may commit); held to ack, then mw_valid=0. Flush flag sticky until ack/timeout.
- mw_fault is 1 only with mw_valid=1; cleared on next latch update.

Optional Feature:
MEM_MISALIGN_TRAP_EN: defined → misaligned half/word detected in IDLE; no bus request, no stall; next edge mw_valid=1, mw_fault=1, mw_dload=0. Undefined → masking behaviour above, mw_fault set only by timeout.

Test Plan:
Word store addr 0x100 data 0xDEADBEEF, ack in 1st REQ cycle → dmem_addr 0x100, strobe 1111, mem_stall high 1 cycle, mw_valid 1 two cycles after accept.
Signed byte load addr 0x203, rdata 0x80FF_1234 → strobe 1111, mw_dload 0xFFFF_FF80. Unsigned half at 0x202 → 0x0000_80FF.
Byte store addr 0x301 data 0x000000AB → wdata 0xABABABAB, strobe 0010. Ack delayed 5 cycles → mem_stall high 6 cycles, dmem bus stable throughout.
ACK_TIMEOUT=4, never ack → dmem_req high 4 cycles, then mw_valid=1, mw_fault=1, stall drops. Ack in later IDLE cycle ignored.
flush in 2nd REQ cycle of load, ack 3rd → mw_valid 0. Back-to-back ALU ops stream with mw_valid 1 every cycle, no stall.
Feature on: word load addr 0x102 → no dmem_req, mw_fault=1. Feature off → dmem_addr 0x100, strobe 1100, mw_fault 0.
